track_playback_reader: RTL and testbench

// Playback path of the DAW; the read-side counterpart of the capture-to-SD path.

---
 rtl/track_playback_reader.sv | 197 +++++++++++++++++++
 tb/tb_track_playback_reader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/track_playback_reader.sv
// Playback reader: fetches SD sectors into a sample FIFO and releases one sample per sample_tick.
// Optional build macro PLAYBACK_LOOP_EN adds end_addr_i and wraps playback back to the start address.
module track_playback_reader #(
   parameter int WORD_WIDTH   = 8,
   parameter int SECTOR_BYTES = 512,
   parameter int FIFO_DEPTH   = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic [31:0]           start_addr_i,
`ifdef PLAYBACK_LOOP_EN
   input  logic [31:0]           end_addr_i,
`endif
   output logic                  sector_req_o,
   output logic [31:0]           sector_addr_o,
   input  logic                  sector_ack_i,
   input  logic                  byte_valid_i,
   input  logic [WORD_WIDTH-1:0] byte_data_i,
   input  logic                  sample_tick_i,
   output logic [WORD_WIDTH-1:0] sample_out_o,
   output logic                  sample_valid_o,
   output logic                  underrun_o,
   output logic                  busy_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (SECTOR_BYTES > 1) ? $clog2(SECTOR_BYTES) : 1;
   localparam logic [AW:0]   SECTOR_CNT = (AW+1)'(SECTOR_BYTES);
   localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] LAST_BYTE  = CW'(SECTOR_BYTES - 1);

   typedef enum logic [2:0] {IDLE, REQ, STREAM, NEXT, WAIT, DRAIN} state_e;

   state_e                state_q, state_d;
   logic [31:0]           sector_addr_q, sector_addr_d;
   logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]           count_q, count_d, free;
   logic                  primed_q, underrun_q;
   logic [WORD_WIDTH-1:0] sample_out_q;
   logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [31:0]           next_addr;
   logic                  flush, push, pop, tick_empty, start_ok, last_byte;

`ifdef PLAYBACK_LOOP_EN
   logic [31:0] loop_addr_q;
   assign next_addr = (sector_addr_q + 32'(SECTOR_BYTES) == end_addr_i) ? loop_addr_q
                                                                        : sector_addr_q + 32'(SECTOR_BYTES);
`else
   assign next_addr = sector_addr_q + 32'(SECTOR_BYTES);
`endif

   assign free      = DEPTH_CNT - count_q;
   assign last_byte = byte_valid_i && (byte_cnt_q == LAST_BYTE);

   always_comb begin
      state_d       = state_q;
      sector_addr_d = sector_addr_q;
      byte_cnt_d    = byte_cnt_q;
      flush         = stop_i;
      push          = 1'b0;
      start_ok      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i && !stop_i) begin
               start_ok      = 1'b1;
               flush         = 1'b1;
               sector_addr_d = start_addr_i;
               state_d       = REQ;
            end
         end
         REQ: begin
            if (stop_i) begin
               state_d = IDLE;
            end else if (sector_ack_i) begin
               byte_cnt_d = '0;
               state_d    = STREAM;
            end
         end
         STREAM: begin
            if (byte_valid_i) begin
               byte_cnt_d = byte_cnt_q + CW'(1);
               push       = !stop_i;
            end
            // A stop that lands on the final byte has nothing left to drain.
            if (stop_i) begin
               state_d = last_byte ? IDLE : DRAIN;
            end else if (last_byte) begin
               state_d = NEXT;
            end
         end
         NEXT: begin
            sector_addr_d = next_addr;
            if (stop_i) begin
               state_d = IDLE;
            end else if (free >= SECTOR_CNT) begin
               state_d = REQ;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (stop_i) begin
               state_d = IDLE;
            end else if (free >= SECTOR_CNT) begin
               state_d = REQ;
            end
         end
         DRAIN: begin
            if (byte_valid_i) begin
               byte_cnt_d = byte_cnt_q + CW'(1);
               if (byte_cnt_q == LAST_BYTE) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pop        = sample_tick_i && primed_q && (count_q != '0) && !flush;
      tick_empty = sample_tick_i && primed_q && (count_q == '0) && !flush;
      count_d    = count_q;
      if (flush) begin
         count_d = '0;
      end else if (push && !pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q       <= IDLE;
         sector_addr_q <= '0;
         byte_cnt_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         primed_q      <= 1'b0;
         underrun_q    <= 1'b0;
         sample_out_q  <= '0;
      end else begin
         state_q       <= state_d;
         sector_addr_q <= sector_addr_d;
         byte_cnt_q    <= byte_cnt_d;
         count_q       <= count_d;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            primed_q <= 1'b0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (count_d >= SECTOR_CNT) primed_q <= 1'b1;
         end
         if (start_ok) begin
            underrun_q <= 1'b0;
         end else if (tick_empty) begin
            underrun_q <= 1'b1;
         end
         if (pop) begin
            sample_out_q <= mem[rd_ptr_q];
         end else if (tick_empty) begin
            sample_out_q <= '0;
         end
      end
   end

`ifdef PLAYBACK_LOOP_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         loop_addr_q <= '0;
      end else if (start_ok) begin
         loop_addr_q <= start_addr_i;
      end
   end
`endif

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr_q] <= byte_data_i;
      end
   end

   assign sector_req_o   = (state_q == REQ);
   assign sector_addr_o  = sector_addr_q;
   assign sample_out_o   = sample_out_q;
   assign sample_valid_o = primed_q;
   assign underrun_o     = underrun_q;
   assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_track_playback_reader.sv
// Self-checking bench for track_playback_reader with small sectors (4 bytes) and an 8-entry FIFO.
// Popped samples are checked against a scoreboard queue filled as bytes are fed in.
module tb_track_playback_reader;

   localparam int SB = 4;
   localparam int FD = 8;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        start_i = 1'b0;
   logic        stop_i = 1'b0;
   logic [31:0] start_addr_i = '0;
`ifdef PLAYBACK_LOOP_EN
   logic [31:0] end_addr_i = 32'h1234_5679;
`endif
   logic        sector_req_o;
   logic [31:0] sector_addr_o;
   logic        sector_ack_i = 1'b0;
   logic        byte_valid_i = 1'b0;
   logic [7:0]  byte_data_i = '0;
   logic        sample_tick_i = 1'b0;
   logic [7:0]  sample_out_o;
   logic        sample_valid_o;
   logic        underrun_o;
   logic        busy_o;

   int testsRun = 0;
   int testsFailed = 0;
   logic [7:0] sbQueue [$];

   typedef struct {
      logic [31:0] startAddr;
      logic [7:0]  firstByte;
      logic [31:0] expAddr2;
      logic [31:0] expAddr3;
   } vec_t;

   vec_t vecs [3];

   track_playback_reader #(.WORD_WIDTH(8), .SECTOR_BYTES(SB), .FIFO_DEPTH(FD)) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .start_i        (start_i),
      .stop_i         (stop_i),
      .start_addr_i   (start_addr_i),
`ifdef PLAYBACK_LOOP_EN
      .end_addr_i     (end_addr_i),
`endif
      .sector_req_o   (sector_req_o),
      .sector_addr_o  (sector_addr_o),
      .sector_ack_i   (sector_ack_i),
      .byte_valid_i   (byte_valid_i),
      .byte_data_i    (byte_data_i),
      .sample_tick_i  (sample_tick_i),
      .sample_out_o   (sample_out_o),
      .sample_valid_o (sample_valid_o),
      .underrun_o     (underrun_o),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change 1ns after the rising edge and outputs are sampled at that same point.
   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulseStart(input logic [31:0] addr);
      start_i = 1'b1;
      start_addr_i = addr;
      cycle();
      start_i = 1'b0;
   endtask

   task automatic pulseStop();
      stop_i = 1'b1;
      cycle();
      stop_i = 1'b0;
   endtask

   task automatic ackReq();
      sector_ack_i = 1'b1;
      cycle();
      sector_ack_i = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] d, input bit expectPush);
      byte_valid_i = 1'b1;
      byte_data_i = d;
      cycle();
      byte_valid_i = 1'b0;
      if (expectPush) sbQueue.push_back(d);
   endtask

   task automatic waitReq(input string name);
      for (int i = 0; i < 20 && !sector_req_o; i++) cycle();
      checkOutput(name, {31'd0, sector_req_o}, 32'd1);
   endtask

   task automatic doTick(input string name, input bit expectUnderrun);
      logic [7:0] exp;
      sample_tick_i = 1'b1;
      cycle();
      sample_tick_i = 1'b0;
      if (expectUnderrun) begin
         checkOutput({name, "_zero"}, {24'd0, sample_out_o}, 32'd0);
         checkOutput({name, "_underrun"}, {31'd0, underrun_o}, 32'd1);
      end else if (sbQueue.size() == 0) begin
         checkOutput({name, "_scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
         exp = sbQueue.pop_front();
         checkOutput(name, {24'd0, sample_out_o}, {24'd0, exp});
      end
   endtask

   // One full playback run: two sectors fill the FIFO, WAIT until drained by ticks, then stop.
   task automatic applyStimulus(input vec_t v);
      pulseStart(v.startAddr);
      checkOutput("run_busy", {31'd0, busy_o}, 32'd1);
      checkOutput("run_req1", {31'd0, sector_req_o}, 32'd1);
      checkOutput("run_addr1", sector_addr_o, v.startAddr);
      pulseStart(32'hDEAD_0000);
      checkOutput("run_start_ignored", sector_addr_o, v.startAddr);
      ackReq();
      checkOutput("run_req_drop", {31'd0, sector_req_o}, 32'd0);
      for (int k = 0; k < SB; k++) sendByte(v.firstByte + 8'(k), 1'b1);
      checkOutput("run_primed", {31'd0, sample_valid_o}, 32'd1);
      waitReq("run_req2");
      checkOutput("run_addr2", sector_addr_o, v.expAddr2);
      ackReq();
      for (int k = SB; k < 2*SB; k++) sendByte(v.firstByte + 8'(k), 1'b1);
      cycle();
      checkOutput("run_wait_noreq", {31'd0, sector_req_o}, 32'd0);
      checkOutput("run_wait_busy", {31'd0, busy_o}, 32'd1);
      for (int k = 0; k < SB; k++) doTick("run_sample", 1'b0);
      waitReq("run_req3");
      checkOutput("run_addr3", sector_addr_o, v.expAddr3);
      pulseStop();
      checkOutput("run_stop_busy", {31'd0, busy_o}, 32'd0);
      checkOutput("run_stop_req", {31'd0, sector_req_o}, 32'd0);
      checkOutput("run_stop_valid", {31'd0, sample_valid_o}, 32'd0);
      sbQueue.delete();
   endtask

   initial begin
      vecs[0] = '{startAddr: 32'h0000_1000, firstByte: 8'h11, expAddr2: 32'h0000_1004, expAddr3: 32'h0000_1008};
      vecs[1] = '{startAddr: 32'hFFFF_FFF8, firstByte: 8'hA0, expAddr2: 32'hFFFF_FFFC, expAddr3: 32'h0000_0000};
      vecs[2] = '{startAddr: 32'h0000_0400, firstByte: 8'h5A, expAddr2: 32'h0000_0404, expAddr3: 32'h0000_0408};

      #3;
      checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
      checkOutput("reset_req", {31'd0, sector_req_o}, 32'd0);
      checkOutput("reset_addr", sector_addr_o, 32'd0);
      checkOutput("reset_valid", {31'd0, sample_valid_o}, 32'd0);
      checkOutput("reset_sample", {24'd0, sample_out_o}, 32'd0);
      #9 rst_n_i = 1'b1;
      cycle();

      for (int i = 0; i < 3; i++) applyStimulus(vecs[i]);

      // Start and stop together: stop wins, the block stays idle.
      start_i = 1'b1;
      stop_i = 1'b1;
      start_addr_i = 32'h7000;
      cycle();
      start_i = 1'b0;
      stop_i = 1'b0;
      checkOutput("startstop_idle", {31'd0, busy_o}, 32'd0);

      // Underrun: drain a primed FIFO, then tick once more.
      pulseStart(32'h2000);
      ackReq();
      for (int k = 0; k < SB; k++) sendByte(8'h21 + 8'(k), 1'b1);
      for (int k = 0; k < SB; k++) doTick("ur_sample", 1'b0);
      checkOutput("ur_not_yet", {31'd0, underrun_o}, 32'd0);
      doTick("ur_tick", 1'b1);
      cycle();
      checkOutput("ur_held", {31'd0, underrun_o}, 32'd1);
      checkOutput("ur_valid_held", {31'd0, sample_valid_o}, 32'd1);
      pulseStop();
      checkOutput("ur_sticky_after_stop", {31'd0, underrun_o}, 32'd1);
      pulseStart(32'h2100);
      checkOutput("ur_cleared_by_start", {31'd0, underrun_o}, 32'd0);
      pulseStop();
      sbQueue.delete();

      // Stop mid-sector: remaining bytes drain without entering the FIFO.
      pulseStart(32'h3000);
      ackReq();
      sendByte(8'h31, 1'b0);
      sendByte(8'h32, 1'b0);
      sample_tick_i = 1'b1;
      cycle();
      sample_tick_i = 1'b0;
      checkOutput("unprimed_tick_ignored", {31'd0, underrun_o}, 32'd0);
      pulseStop();
      checkOutput("drain_busy", {31'd0, busy_o}, 32'd1);
      checkOutput("drain_valid", {31'd0, sample_valid_o}, 32'd0);
      checkOutput("drain_noreq", {31'd0, sector_req_o}, 32'd0);
      sendByte(8'h33, 1'b0);
      checkOutput("drain_busy2", {31'd0, busy_o}, 32'd1);
      sendByte(8'h34, 1'b0);
      checkOutput("drain_idle", {31'd0, busy_o}, 32'd0);
      checkOutput("drain_idle_valid", {31'd0, sample_valid_o}, 32'd0);

      // Fresh playback: a stray byte during REQ must not be captured.
      pulseStart(32'h4000);
      sendByte(8'h99, 1'b0);
      ackReq();
      for (int k = 0; k < SB; k++) sendByte(8'h41 + 8'(k), 1'b1);
      checkOutput("restart_primed", {31'd0, sample_valid_o}, 32'd1);
      doTick("restart_first", 1'b0);
      pulseStop();
      sbQueue.delete();

`ifdef PLAYBACK_LOOP_EN
      // Looping between 0x0 and 0x8 keeps playing without re-priming.
      end_addr_i = 32'h8;
      pulseStart(32'h0);
      checkOutput("loop_addr_a", sector_addr_o, 32'h0);
      ackReq();
      for (int k = 0; k < SB; k++) sendByte(8'h60 + 8'(k), 1'b1);
      waitReq("loop_req_b");
      checkOutput("loop_addr_b", sector_addr_o, 32'h4);
      ackReq();
      for (int k = 0; k < SB; k++) sendByte(8'h64 + 8'(k), 1'b1);
      for (int k = 0; k < SB; k++) doTick("loop_sample", 1'b0);
      waitReq("loop_req_c");
      checkOutput("loop_addr_c", sector_addr_o, 32'h0);
      ackReq();
      for (int k = 0; k < SB; k++) sendByte(8'h68 + 8'(k), 1'b1);
      for (int k = 0; k < SB; k++) doTick("loop_sample2", 1'b0);
      waitReq("loop_req_d");
      checkOutput("loop_addr_d", sector_addr_o, 32'h4);
      checkOutput("loop_still_primed", {31'd0, sample_valid_o}, 32'd1);
      pulseStop();
      sbQueue.delete();
      end_addr_i = 32'h1234_5679;
`endif

      // Asynchronous reset in the middle of a sector.
      pulseStart(32'h5000);
      ackReq();
      sendByte(8'h51, 1'b0);
      sendByte(8'h52, 1'b0);
      rst_n_i = 1'b0;
      #1;
      checkOutput("arst_busy", {31'd0, busy_o}, 32'd0);
      checkOutput("arst_req", {31'd0, sector_req_o}, 32'd0);
      checkOutput("arst_addr", sector_addr_o, 32'd0);
      checkOutput("arst_sample", {24'd0, sample_out_o}, 32'd0);
      checkOutput("arst_valid", {31'd0, sample_valid_o}, 32'd0);
      checkOutput("arst_underrun", {31'd0, underrun_o}, 32'd0);
      #3 rst_n_i = 1'b1;
      cycle();
      cycle();
      checkOutput("arst_release_idle", {31'd0, busy_o}, 32'd0);
      checkOutput("arst_release_req", {31'd0, sector_req_o}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
